// File: rtl/jt63701_rom_arb.sv
// Two-requester arbiter sharing one ROM/SDRAM read port, with a one-entry
// fetch cache per requester so repeated reads of an address stay local.
module jt63701_rom_arb #(
  parameter int AW = 14,
  parameter int RR = 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          m0_cs,
  input  logic [AW-1:0] m0_addr,
  output logic [7:0]    m0_data,
  output logic          m0_ok,
  input  logic          m1_cs,
  input  logic [AW-1:0] m1_addr,
  output logic [7:0]    m1_data,
  output logic          m1_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic          gnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    WAIT_OK = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    valid;
  logic [AW-1:0] c_addr [2];
  logic [7:0]    c_data [2];
  logic [AW-1:0] lat_addr;
  logic          stale;
  logic          hit0, hit1, req0, req1;
  logic          grant_en, winner, fill_en;

  assign hit0    = valid[0] && (c_addr[0] == m0_addr);
  assign hit1    = valid[1] && (c_addr[1] == m1_addr);
  assign req0    = m0_cs && !hit0;
  assign req1    = m1_cs && !hit1;
  assign m0_ok   = m0_cs && hit0;
  assign m1_ok   = m1_cs && hit1;
  assign m0_data = c_data[0];
  assign m1_data = c_data[1];

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    state_nx = state;
    grant_en = 1'b0;
    winner   = 1'b0;
    fill_en  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_en = 1'b1;
          if (req0 && req1) winner = (RR != 0) ? ~gnt : 1'b0;
          else              winner = req1;
          state_nx = SETTLE;
        end
      end
      // rom_ok is deliberately ignored here: it may still belong to the last access
      SETTLE:  state_nx = WAIT_OK;
      WAIT_OK: begin
        if (rom_ok) begin
          fill_en  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      lat_addr  <= '0;
      busy      <= 1'b0;
      gnt       <= 1'b1;
      stale     <= 1'b0;
      valid     <= '0;
      // NOTE: the two cache entries are plain registers, not RAM, so they are
      // reset along with the rest of the state.
      c_addr[0] <= '0;
      c_addr[1] <= '0;
      c_data[0] <= '0;
      c_data[1] <= '0;
    end else begin
      if (grant_en) begin
        gnt      <= winner;
        rom_addr <= winner ? m1_addr : m0_addr;
        lat_addr <= winner ? m1_addr : m0_addr;
        rom_cs   <= 1'b1;
        busy     <= 1'b1;
        stale    <= 1'b0;
      end else if (flush && state != IDLE) begin
        stale <= 1'b1;
      end
      if (fill_en) begin
        valid[gnt]  <= !(stale || flush);
        c_addr[gnt] <= lat_addr;
        c_data[gnt] <= rom_data;
        rom_cs      <= 1'b0;
        busy        <= 1'b0;
      end
      // flush overrides any fill written at the same edge
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jt63701_rom_arb.sv
// Randomised bench: a round-robin and a fixed-priority instance run side by
// side against a transaction-level model of the shared-port arbiter.
module tb_jt63701_rom_arb;

  localparam int AW = 14;

  typedef struct packed {
    logic [1:0]          v;      // cache valid per requester
    logic [1:0][AW-1:0]  a;      // cache address
    logic [1:0][7:0]     d;      // cache data
    logic                act;    // an access is outstanding
    logic                own;    // owner of current/last access
    logic [AW-1:0]       raddr;  // address presented on the shared port
    int                  age;    // edges seen since the grant
    logic                taint;  // flush seen while outstanding
  } mdl_t;

  logic clk, rst, flush;
  logic m0_cs, m1_cs, rom_ok;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [7:0] rom_data;

  logic [1:0]         m0_ok_o, m1_ok_o, rom_cs_o, gnt_o, busy_o;
  logic [1:0][7:0]    m0_data_o, m1_data_o;
  logic [1:0][AW-1:0] rom_addr_o;

  mdl_t m [2];
  int n_vec = 0;
  int n_bad = 0;

  jt63701_rom_arb #(.AW(AW), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .flush(flush),
    .m0_cs(m0_cs), .m0_addr(m0_addr), .m0_data(m0_data_o[0]), .m0_ok(m0_ok_o[0]),
    .m1_cs(m1_cs), .m1_addr(m1_addr), .m1_data(m1_data_o[0]), .m1_ok(m1_ok_o[0]),
    .rom_cs(rom_cs_o[0]), .rom_addr(rom_addr_o[0]), .rom_data(rom_data), .rom_ok(rom_ok),
    .gnt(gnt_o[0]), .busy(busy_o[0])
  );

  jt63701_rom_arb #(.AW(AW), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .flush(flush),
    .m0_cs(m0_cs), .m0_addr(m0_addr), .m0_data(m0_data_o[1]), .m0_ok(m0_ok_o[1]),
    .m1_cs(m1_cs), .m1_addr(m1_addr), .m1_data(m1_data_o[1]), .m1_ok(m1_ok_o[1]),
    .rom_cs(rom_cs_o[1]), .rom_addr(rom_addr_o[1]), .rom_data(rom_data), .rom_ok(rom_ok),
    .gnt(gnt_o[1]), .busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t model_reset();
    mdl_t s;
    s     = '0;
    s.own = 1'b1;
    return s;
  endfunction

  function automatic logic model_hit(input mdl_t s, input int n, input logic [AW-1:0] addr);
    return s.v[n] && (s.a[n] == addr);
  endfunction

  // One clock edge of the arbiter, expressed as transactions.
  function automatic mdl_t model_edge(input mdl_t s, input bit rr);
    logic r0, r1;
    if (s.act) begin
      if (s.age >= 1 && rom_ok) begin
        s.v[s.own] = !(s.taint || flush);
        s.a[s.own] = s.raddr;
        s.d[s.own] = rom_data;
        s.act      = 1'b0;
      end else begin
        s.age++;
        if (flush) s.taint = 1'b1;
      end
    end else begin
      r0 = m0_cs && !model_hit(s, 0, m0_addr);
      r1 = m1_cs && !model_hit(s, 1, m1_addr);
      if (r0 || r1) begin
        if (r0 && r1) s.own = rr ? !s.own : 1'b0;
        else          s.own = r1;
        s.raddr = s.own ? m1_addr : m0_addr;
        s.act   = 1'b1;
        s.age   = 0;
        s.taint = 1'b0;
      end
    end
    if (flush) s.v = '0;
    return s;
  endfunction

  task automatic check_outputs(input int k, input int cyc);
    logic e0, e1;
    string p;
    p  = $sformatf("c%0d %s", cyc, (k == 0) ? "rr" : "fp");
    e0 = m0_cs && model_hit(m[k], 0, m0_addr);
    e1 = m1_cs && model_hit(m[k], 1, m1_addr);
    check({p, " m0_ok"}, 32'(m0_ok_o[k]), 32'(e0));
    check({p, " m1_ok"}, 32'(m1_ok_o[k]), 32'(e1));
    if (e0) check({p, " m0_data"}, 32'(m0_data_o[k]), 32'(m[k].d[0]));
    if (e1) check({p, " m1_data"}, 32'(m1_data_o[k]), 32'(m[k].d[1]));
    check({p, " rom_cs"},   32'(rom_cs_o[k]),   32'(m[k].act));
    check({p, " busy"},     32'(busy_o[k]),     32'(m[k].act));
    check({p, " gnt"},      32'(gnt_o[k]),      32'(m[k].own));
    check({p, " rom_addr"}, 32'(rom_addr_o[k]), 32'(m[k].raddr));
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] pool [6];
    pool[0] = 14'h0010; pool[1] = 14'h0020; pool[2] = 14'h0123;
    pool[3] = 14'h0000; pool[4] = 14'h2000; pool[5] = 14'h3FFF;
    return pool[$urandom_range(0, 5)];
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; rom_ok = 1'b0; rom_data = 8'h00;
    m0_cs = 1'b0; m1_cs = 1'b0; m0_addr = '0; m1_addr = '0;
    m[0] = model_reset();
    m[1] = model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) check_outputs(k, -1);
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // address churn is kept low so fills are frequently followed by hits
      m0_cs = ($urandom_range(0, 3) != 0);
      m1_cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) m0_addr = pick_addr();
      if ($urandom_range(0, 3) == 0) m1_addr = pick_addr();
      if (cyc >= 1000 && cyc < 1500) rom_ok = 1'b1;
      else                            rom_ok = ($urandom_range(0, 2) == 0);
      rom_data = 8'($urandom);
      if (cyc >= 1500 && cyc < 2500) flush = ($urandom_range(0, 7) == 0);
      else                           flush = ($urandom_range(0, 63) == 0);

      if (m[0].act && m[0].age >= 1 && $urandom_range(0, 39) == 0) begin
        #1 rst = 1'b1;
        #1;
        m[0] = model_reset();
        m[1] = model_reset();
        for (int k = 0; k < 2; k++) check_outputs(k, cyc);
        rst = 1'b0;
      end

      #1;
      for (int k = 0; k < 2; k++) check_outputs(k, cyc);
      @(posedge clk);
      m[0] = model_edge(m[0], 1'b1);
      m[1] = model_edge(m[1], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jt63701_rom_arb.md
Name: jt63701_rom_arb

Overview:
Two-requester arbiter that shares one external ROM/SDRAM read port between the 63701 MCU internal-PROM fetch path and a second requester (main CPU or sound CPU ROM reads).
Each requester has a one-entry fetch cache, so repeated reads of the same address do not touch the shared port.
It sits between the MCU wrapper's rom_addr/rom_cs/rom_data/rom_ok pins and the SDRAM/ROM controller, and uses the same cs/ok handshake on both sides.

Parameters:
AW, 14, address width of requesters and ROM port.
RR, 1, 1 = round-robin arbitration; 0 = fixed priority, m0 always wins.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
flush  in  1  invalidates both caches (ROM download/reload).
m0_cs  in  1  requester 0 (MCU) read request.
m0_addr  in  AW  requester 0 address.
m0_data  out  8  requester 0 read data.
m0_ok  out  1  requester 0 data valid for the current m0_addr.
m1_cs  in  1  requester 1 read request.
m1_addr  in  AW  requester 1 address.
m1_data  out  8  requester 1 read data.
m1_ok  out  1  requester 1 data valid for the current m1_addr.
rom_cs  out  1  shared port request.
rom_addr  out  AW  shared port address.
rom_data  in  8  shared port data.
rom_ok  in  1  shared port data valid.
gnt  out  1  index of the requester owning the current or last access.
busy  out  1  a shared-port access is in flight.

Behaviour:
Reset (asynchronous) values:
- State IDLE; both cache valid bits 0; cache addr/data 0.
- rom_cs=0, rom_addr=0, busy=0, gnt=1 (so m0 wins the first tie).
- Reset mid-access abandons the access; no fill occurs.

Cache and outputs (per requester N):
- hitN = validN && addrN==mN_addr.
- mN_ok = mN_cs && hitN (combinational).
- mN_data = cached data N (combinational). Value is undefined-but-stable when mN_ok=0.
- reqN = mN_cs && !hitN.

FSM:
- IDLE:
  - If no req: stay in IDLE.
  - If exactly one req: grant it.
  - If both req, RR=1: grant the requester not equal to gnt.
  - If both req, RR=0: grant m0.
  - On grant, at the clock edge: gnt<=winner; rom_addr<=mN_addr of the winner; lat_addr<=same; rom_cs<=1; busy<=1; go to SETTLE.
- SETTLE (one cycle):
  - rom_ok is ignored, so a stale ok from the previous access is rejected.
  - Go to WAIT.
- WAIT:
  - rom_cs and rom_addr are held stable.
  - On rom_ok: cache[gnt] <= {valid=1, lat_addr, rom_data}; rom_cs<=0; busy<=0; go to IDLE.
- rom_cs is low for at least one cycle between accesses.
- A new grant can occur in the cycle after a fill.

Latency:
- Miss: rom_cs rises 1 cycle after mN_cs.
- Fill happens at the edge where rom_ok is sampled in WAIT.
- mN_ok goes high the cycle after the fill, if mN_addr is unchanged.
- Hit: mN_ok in the same cycle, zero latency.

Boundary conditions:
- Requester address changes during SETTLE/WAIT: the access completes and the cache fills with lat_addr, giving no hit for the new address. A new miss is then arbitrated from IDLE. rom_addr never changes mid-access.
- Requester drops cs mid-access: the access still completes and fills.
- flush:
  - Clears both valid bits at the edge.
  - If flush is asserted in SETTLE/WAIT, or in the same cycle rom_ok is sampled, the fill is written with valid=0.
  - flush has priority over fill.
- A requester whose cache hits never blocks the other requester.
- rom_ok held permanently high still yields at most one fill per access, because SETTLE is mandatory.
- Address compare uses the full AW bits; there is no wrap behaviour.

Test Plan:
1. Single miss then hit:
   - Stimulus: m0_cs=1, m0_addr=0x0123; ROM returns 0x5A with rom_ok 3 cycles after rom_cs.
   - Required: rom_cs rises the next cycle with rom_addr=0x0123; one cycle after the fill, m0_ok=1 and m0_data=0x5A.
   - Then re-request 0x0123: no further rom_cs pulse.
2. Round-robin:
   - Stimulus: RR=1; m0 and m1 miss continuously with incrementing addresses.
   - Required: grants alternate 0,1,0,1; first grant is 0 after reset; rom_cs is low for at least one cycle between accesses.
3. Fixed priority:
   - Stimulus: RR=0; both requesters miss continuously.
   - Required: m1 is granted only when m0 hits or m0_cs=0.
4. Stale ok and address change:
   - Stimulus: rom_ok tied high; m0_addr changes 0x0010→0x0020 during WAIT.
   - Required: exactly one fill of 0x0010 (m0_ok stays 0), then a new access with rom_addr=0x0020; rom_addr stays stable during each access.
5. Flush:
   - Stimulus: flush pulsed in the same cycle rom_ok arrives.
   - Required: both caches invalid afterwards, m0_ok=0, and a re-request issues a new rom_cs.
6. Reset mid-access:
   - Stimulus: rst asserted during WAIT.
   - Required: rom_cs=0, busy=0, gnt=1 immediately (asynchronous); no fill; after release, the first request misses.
